emmc_traffic_gen: RTL and testbench

//  Parametrised stimulus/checker driving the host side of emmc_sm (we/start/blk_cnt/dat/dvalid/ready).

---
 rtl/emmc_traffic_gen_pkg.sv | 36 +++
 rtl/emmc_pattern_gen.sv | 39 +++
 rtl/emmc_traffic_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_emmc_traffic_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emmc_traffic_gen_pkg.sv
// Shared types and constants for the eMMC traffic generator.
package emmc_traffic_gen_pkg;

  // Default jedec_p block length in bytes.
  localparam int DEF_BLK_BYTES = 512;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    WR_ONLY        = 2'd0,
    RD_ONLY        = 2'd1,
    WR_THEN_VERIFY = 2'd2,
    ALTERNATE      = 2'd3
  } tg_mode_e;

  typedef enum logic {
    PAT_INCR = 1'b0,
    PAT_LFSR = 1'b1
  } tg_pat_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    ACCEPT = 3'd2,
    XFER   = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } tg_state_e;

  // One Galois LFSR step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/emmc_pattern_gen.sv
// Data pattern source shared by the write driver and the read checker.
// The current byte is always available; restart rewinds to the seed,
// step advances by one byte.
module emmc_pattern_gen
  import emmc_traffic_gen_pkg::*;
#(
  parameter int          DAT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      seed_i,
  input  logic             restart_i,
  input  logic             step_i,
  input  logic             pattern_i,
  output logic [DAT_W-1:0] byte_o
);

  logic [15:0]      lfsr_q;
  logic [DAT_W-1:0] idx_q;

  // Restart has priority over step so a transfer always begins at index 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
      idx_q  <= '0;
    end else if (restart_i) begin
      lfsr_q <= seed_i;
      idx_q  <= '0;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
      idx_q  <= idx_q + 1'b1;
    end
  end

  // INCR byte is the index modulo 2^DAT_W; LFSR byte is the low register bits.
  assign byte_o = pattern_i ? lfsr_q[DAT_W-1:0] : idx_q;

endmodule

// File: rtl/emmc_traffic_gen.sv
// Host-side stimulus generator and read-back checker for emmc_sm.
// Issues write/read transfers in the selected mode, drives pattern data,
// checks read data and byte counts, and reports a pass/fail summary.
//
// Handshake with emmc_sm: a command is offered only while emmc_ready_i = 1
// and is signalled by a single-cycle emmc_start_o; emmc_ready_i falling means
// the command was taken, and emmc_ready_i rising again marks transfer end.
// Every cycle with emmc_dvalid_i = 1 transfers exactly one byte (write data
// consumed, or read data valid on emmc_rd_dat_i in that same cycle).
module emmc_traffic_gen
  import emmc_traffic_gen_pkg::*;
#(
  parameter int          DAT_W     = 8,
  parameter int          BLK_BYTES = DEF_BLK_BYTES,
  parameter int          BLK_CNT_W = 16,
  parameter int          ITER_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 go_i,
  input  logic                 abort_i,
  input  logic [1:0]           mode_i,
  input  logic                 pattern_i,
  input  logic [BLK_CNT_W-1:0] blk_cnt_i,
  input  logic [ITER_W-1:0]    iter_i,
  input  logic                 emmc_ready_i,
  input  logic                 emmc_dvalid_i,
  input  logic [DAT_W-1:0]     emmc_rd_dat_i,
  output logic                 emmc_we_o,
  output logic                 emmc_start_o,
  output logic [BLK_CNT_W-1:0] emmc_blk_cnt_o,
  output logic [DAT_W-1:0]     emmc_wr_dat_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [31:0]          err_cnt_o,
  output logic [31:0]          first_err_o,
  output logic [ITER_W-1:0]    xfer_cnt_o,
  output logic [2:0]           state_o
);

  // Control state and latched run configuration
  tg_state_e            state_q;
  tg_mode_e             mode_q;
  tg_pat_e              pat_q;
  logic [BLK_CNT_W-1:0] blk_cnt_q;
  logic [ITER_W-1:0]    iter_q;
  logic [31:0]          exp_bytes_q;
  logic [31:0]          byte_idx_q;
  logic                 abort_q;

  // Registered outputs
  logic                 we_q;
  logic                 start_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [31:0]          err_cnt_q;
  logic [31:0]          first_err_q;
  logic [ITER_W-1:0]    xfer_cnt_q;

  // Combinational helpers
  logic [BLK_CNT_W-1:0] blk_eff;
  logic [DAT_W-1:0]     pat_byte;
  logic                 pat_restart;
  logic                 pat_step;
  logic                 dv_err;
  logic                 short_err;
  logic [1:0]           err_add;
  logic [31:0]          end_cnt;
  logic [31:0]          first_idx;
  logic [32:0]          err_sum;
  logic [31:0]          err_cnt_d;
  logic                 iter_done;
  logic [ITER_W-1:0]    xfer_cnt_d;
  logic                 finish;

  assign blk_eff     = (blk_cnt_i == '0) ? BLK_CNT_W'(1) : blk_cnt_i;
  assign pat_restart = (state_q == ISSUE) && emmc_ready_i;
  assign pat_step    = (state_q == XFER) && emmc_dvalid_i;

  emmc_pattern_gen #(
    .DAT_W     (DAT_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .seed_i    (LFSR_SEED),
    .restart_i (pat_restart),
    .step_i    (pat_step),
    .pattern_i (pat_q == PAT_LFSR),
    .byte_o    (pat_byte)
  );

  // Per-cycle error detection: data/excess errors on dvalid, short count at transfer end
  always_comb begin
    dv_err    = 1'b0;
    short_err = 1'b0;
    end_cnt   = byte_idx_q + {31'd0, emmc_dvalid_i};
    if (state_q == XFER) begin
      if (emmc_dvalid_i) begin
        dv_err = (byte_idx_q >= exp_bytes_q) || (!we_q && (emmc_rd_dat_i != pat_byte));
      end
      if (emmc_ready_i) begin
        short_err = (end_cnt < exp_bytes_q);
      end
    end
    err_add   = {1'b0, dv_err} + {1'b0, short_err};
    // A byte error happens earlier in the stream than the short-count position.
    first_idx = dv_err ? byte_idx_q : end_cnt;
    err_sum   = {1'b0, err_cnt_q} + {31'd0, err_add};
    err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  end

  // Iteration bookkeeping evaluated in NEXT
  always_comb begin
    // A verify pair completes only after its read half.
    iter_done  = (mode_q != WR_THEN_VERIFY) || !we_q;
    xfer_cnt_d = xfer_cnt_q + {{(ITER_W-1){1'b0}}, iter_done};
    finish     = abort_q || abort_i ||
                 ((iter_q != '0) && iter_done && (xfer_cnt_d == iter_q));
  end

  // Main control FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= WR_ONLY;
      pat_q       <= PAT_INCR;
      blk_cnt_q   <= '0;
      iter_q      <= '0;
      exp_bytes_q <= '0;
      byte_idx_q  <= '0;
      abort_q     <= 1'b0;
      we_q        <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b1;
      err_cnt_q   <= '0;
      first_err_q <= '1;
      xfer_cnt_q  <= '0;
    end else begin
      // Abort is remembered for the whole run and honoured at the next NEXT.
      if (abort_i && busy_q) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (go_i) begin
            mode_q      <= tg_mode_e'(mode_i);
            pat_q       <= tg_pat_e'(pattern_i);
            blk_cnt_q   <= blk_eff;
            iter_q      <= iter_i;
            exp_bytes_q <= 32'(blk_eff) * 32'(BLK_BYTES);
            we_q        <= (tg_mode_e'(mode_i) != RD_ONLY);
            abort_q     <= 1'b0;
            pass_q      <= 1'b1;
            err_cnt_q   <= '0;
            first_err_q <= '1;
            xfer_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (emmc_ready_i) begin
            start_q    <= 1'b1;
            byte_idx_q <= '0;
            state_q    <= ACCEPT;
          end
        end
        ACCEPT: begin
          start_q <= 1'b0;
          if (!emmc_ready_i) begin
            state_q <= XFER;
          end
        end
        XFER: begin
          if (emmc_dvalid_i) begin
            byte_idx_q <= byte_idx_q + 32'd1;
          end
          if (err_add != 2'd0) begin
            err_cnt_q <= err_cnt_d;
            pass_q    <= 1'b0;
            if (&first_err_q) begin
              first_err_q <= first_idx;
            end
          end
          if (emmc_ready_i) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          xfer_cnt_q <= xfer_cnt_d;
          case (mode_q)
            WR_ONLY: we_q <= 1'b1;
            RD_ONLY: we_q <= 1'b0;
            default: we_q <= !we_q;
          endcase
          if (finish) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= ISSUE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign emmc_we_o      = we_q;
  assign emmc_start_o   = start_q;
  assign emmc_blk_cnt_o = blk_cnt_q;
  assign emmc_wr_dat_o  = pat_byte;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign err_cnt_o      = err_cnt_q;
  assign first_err_o    = first_err_q;
  assign xfer_cnt_o     = xfer_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_emmc_traffic_gen.sv
// Bench for emmc_traffic_gen with a behavioural emmc_sm (loopback RAM,
// random dvalid gaps) and directed run scenarios.
module tb_emmc_traffic_gen;

  localparam int DAT_W     = 8;
  localparam int BLK_BYTES = 512;
  localparam int BLK_CNT_W = 16;
  localparam int ITER_W    = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT inputs
  logic                 go = 1'b0;
  logic                 abort = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic                 pattern = 1'b0;
  logic [BLK_CNT_W-1:0] blk = '0;
  logic [ITER_W-1:0]    iter = '0;
  logic                 ready_m = 1'b1;
  logic                 dvalid_m = 1'b0;
  logic [DAT_W-1:0]     rd_dat_m = '0;

  // DUT outputs
  logic                 we_o, start_o, busy_o, done_o, pass_o;
  logic [BLK_CNT_W-1:0] blk_cnt_o;
  logic [DAT_W-1:0]     wr_dat_o;
  logic [31:0]          err_cnt_o, first_err_o;
  logic [ITER_W-1:0]    xfer_cnt_o;
  logic [2:0]           dbg_state;

  emmc_traffic_gen #(
    .DAT_W(DAT_W), .BLK_BYTES(BLK_BYTES), .BLK_CNT_W(BLK_CNT_W),
    .ITER_W(ITER_W), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .abort_i(abort),
    .mode_i(mode), .pattern_i(pattern), .blk_cnt_i(blk), .iter_i(iter),
    .emmc_ready_i(ready_m), .emmc_dvalid_i(dvalid_m), .emmc_rd_dat_i(rd_dat_m),
    .emmc_we_o(we_o), .emmc_start_o(start_o), .emmc_blk_cnt_o(blk_cnt_o),
    .emmc_wr_dat_o(wr_dat_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_err_o(first_err_o), .xfer_cnt_o(xfer_cnt_o),
    .state_o(dbg_state)
  );

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  logic [DAT_W-1:0] exp_q[$];
  logic [15:0]      lfsr_tab[0:2047];
  logic [DAT_W-1:0] ram[0:2047];

  // Scenario knobs
  logic cur_pat = 1'b0;
  int   exp_blk = 1;
  int   corrupt_idx = -1;
  int   short_len = -1;
  int   starts = 0;
  int   done_cnt = 0;

  // Model-of-emmc_sm state
  logic m_busy = 1'b0;
  logic m_we = 1'b0;
  int   m_i = 0;
  int   m_n = 0;
  int   m_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DAT_W-1:0] exp_byte(input int k);
    if (cur_pat) return lfsr_tab[k][DAT_W-1:0];
    return DAT_W'(k);
  endfunction

  // LFSR sequence from the polynomial: shift right, feedback into bit 15, taps at 13/12/10.
  initial begin
    logic [15:0] s;
    logic fb;
    s = 16'hACE1;
    for (int k = 0; k < 2048; k++) begin
      lfsr_tab[k] = s;
      fb = s[0];
      s = {fb, s[15:1]} ^ (fb ? 16'h3400 : 16'h0000);
    end
  end

  // Behavioural emmc_sm plus per-byte write-data compare against exp_q
  initial begin : emmc_model
    logic [DAT_W-1:0] e;
    forever begin
      @(negedge clk);
      dvalid_m = 1'b0;
      if (start_o && !ready_m) check("start_while_busy", 32'(start_o), 32'd0);
      if (rst) begin
        ready_m = 1'b1;
        m_busy = 1'b0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (ready_m && start_o) begin
          m_busy = 1'b1;
          ready_m = 1'b0;
          m_we = we_o;
          m_i = 0;
          m_gap = 2;
          starts++;
          check("blk_cnt_at_start", 32'(blk_cnt_o), 32'(exp_blk));
          m_n = exp_blk * BLK_BYTES;
          if (!m_we && short_len >= 0) m_n = short_len;
          if (m_we) for (int k = 0; k < m_n; k++) exp_q.push_back(exp_byte(k));
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_i < m_n) begin
        dvalid_m = 1'b1;
        if (m_we) begin
          ram[m_i] = wr_dat_o;
          if (exp_q.size() == 0) begin
            check("wr_queue_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("wr_dat", 32'(wr_dat_o), 32'(e));
          end
        end else begin
          rd_dat_m = ram[m_i];
          if (m_i == corrupt_idx) rd_dat_m[0] = ~rd_dat_m[0];
        end
        m_i++;
        m_gap = $urandom_range(0, 2);
      end else begin
        ready_m = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // done_o pulse counter
  initial forever begin
    @(negedge clk);
    if (done_o) done_cnt++;
  end

  // Driver: launch one run
  task automatic start_run(input logic [1:0] m, input logic p, input int b, input int it);
    @(negedge clk);
    mode = m; pattern = p; blk = BLK_CNT_W'(b); iter = ITER_W'(it);
    cur_pat = p;
    exp_blk = (b == 0) ? 1 : b;
    done_cnt = 0;
    starts = 0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
    end
  endtask

  task automatic finish_checks(input string tag, input int e_starts, input int e_xfer,
                               input logic e_pass, input int e_err, input logic [31:0] e_first);
    wait_done(60000);
    check({tag, "_pass"}, 32'(pass_o), 32'(e_pass));
    check({tag, "_err_cnt"}, err_cnt_o, 32'(e_err));
    check({tag, "_first_err"}, first_err_o, e_first);
    check({tag, "_xfer_cnt"}, 32'(xfer_cnt_o), 32'(e_xfer));
    check({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
    repeat (10) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_starts"}, 32'(starts), 32'(e_starts));
    check({tag, "_pass_held"}, 32'(pass_o), 32'(e_pass));
  endtask

  // Global watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    // Reset values
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd1);
    check("rst_err_cnt", err_cnt_o, 32'd0);
    check("rst_first_err", first_err_o, 32'hFFFF_FFFF);
    check("rst_xfer_cnt", 32'(xfer_cnt_o), 32'd0);
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_blk_cnt", 32'(blk_cnt_o), 32'd0);
    check("rst_wr_dat", 32'(wr_dat_o), 32'd0);
    rst = 1'b0;

    // 1: write-then-verify, INCR, one block
    start_run(2'd2, 1'b0, 1, 1);
    finish_checks("t1", 2, 1, 1'b1, 0, 32'hFFFF_FFFF);
    check("t1_ram255", 32'(ram[255]), 32'hFF);
    check("t1_ram256", 32'(ram[256]), 32'h00);
    check("t1_ram511", 32'(ram[511]), 32'hFF);

    // 2: LFSR, three blocks, four pairs
    start_run(2'd2, 1'b1, 3, 4);
    finish_checks("t2", 8, 4, 1'b1, 0, 32'hFFFF_FFFF);
    check("t2_lfsr0", 32'(ram[0]), 32'hE1);
    check("t2_lfsr1", 32'(ram[1]), 32'h70);
    check("t2_lfsr2", 32'(ram[2]), 32'h38);
    check("t2_lfsr3", 32'(ram[3]), 32'h9C);

    // 3: corrupted read byte 700
    corrupt_idx = 700;
    start_run(2'd2, 1'b0, 2, 1);
    finish_checks("t3", 2, 1, 1'b0, 1, 32'd700);
    corrupt_idx = -1;

    // 4: infinite alternate, abort during transfer 5
    start_run(2'd3, 1'b0, 1, 0);
    n = 0;
    while (!(starts == 5 && m_i > 50) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_xfer5", 32'(starts), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    finish_checks("t4", 5, 5, 1'b1, 0, 32'hFFFF_FFFF);

    // 5: short read after 300 bytes, blk_cnt 0 treated as 1
    short_len = 300;
    start_run(2'd2, 1'b0, 0, 1);
    check("t5_blk_cnt_zero", 32'(blk_cnt_o), 32'd1);
    finish_checks("t5", 2, 1, 1'b0, 1, 32'd300);
    short_len = -1;

    // 6: reset mid-transfer, then clean runs
    start_run(2'd0, 1'b0, 1, 1);
    n = 0;
    while (!(m_busy && m_i > 100) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_xfer", 32'(m_i > 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_start", 32'(start_o), 32'd0);
    check("t6_first_err", first_err_o, 32'hFFFF_FFFF);
    check("t6_err_cnt", err_cnt_o, 32'd0);
    check("t6_pass", 32'(pass_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    start_run(2'd0, 1'b0, 1, 2);
    finish_checks("t6w", 2, 2, 1'b1, 0, 32'hFFFF_FFFF);
    start_run(2'd1, 1'b0, 1, 1);
    finish_checks("t6r", 1, 1, 1'b1, 0, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
